// File: rtl/ltc231x_stream_reader.sv
// LTC231x serial ADC reader: CNV/SCK generation, MSB-first SDO capture,
// single-shot or fixed-period sampling, valid/ready output with overrun flag.
module ltc231x_stream_reader #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned CONV_CYCLES   = 3,
    parameter int unsigned SCK_DIV       = 1,
    parameter int unsigned SAMPLE_PERIOD = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cont_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  overrun,
    output logic                  busy,
    output logic                  cnv,
    output logic                  sck,
    input  logic                  sdo
);

    localparam int unsigned T_MIN    = CONV_CYCLES + 2 * SCK_DIV * DATA_WIDTH + 2;
    localparam int unsigned PERIOD   = (SAMPLE_PERIOD > T_MIN) ? SAMPLE_PERIOD : T_MIN;
    localparam int unsigned CONV_W   = $clog2(CONV_CYCLES + 1);
    localparam int unsigned BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam int unsigned DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned PERIOD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_READ,
        S_LOAD,
        S_WAIT
    } state_t;

    state_t                state;
    logic [CONV_W-1:0]     conv_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic [PERIOD_W-1:0]   period_cnt;
    logic [DATA_WIDTH-1:0] shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            conv_cnt   <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            period_cnt <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
            cnv        <= 1'b0;
            sck        <= 1'b1;
        end else begin
            overrun <= 1'b0;
            busy    <= 1'b1;
            // Consumer handshake; a LOAD in the same cycle overrides the clear.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    busy <= start | cont_en;
                    if (start || cont_en) begin
                        state      <= S_CONVERT;
                        cnv        <= 1'b1;
                        conv_cnt   <= '0;
                        period_cnt <= '0;
                    end
                end
                S_CONVERT: begin
                    period_cnt <= period_cnt + PERIOD_W'(1);
                    if (conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
                        state   <= S_READ;
                        cnv     <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        conv_cnt <= conv_cnt + CONV_W'(1);
                    end
                end
                S_READ: begin
                    period_cnt <= period_cnt + PERIOD_W'(1);
                    if (div_cnt == DIV_W'(SCK_DIV - 1)) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        // The edge that raises SCK captures the current SDO bit.
                        if (!sck) begin
                            shreg <= {shreg[DATA_WIDTH-2:0], sdo};
                            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                                state <= S_LOAD;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_LOAD: begin
                    period_cnt <= period_cnt + PERIOD_W'(1);
                    data_out   <= shreg;
                    data_valid <= 1'b1;
                    overrun    <= data_valid & ~data_ready;
                    state      <= cont_en ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (!cont_en) begin
                        state <= S_IDLE;
                    end else if (period_cnt == PERIOD_W'(PERIOD - 1)) begin
                        state      <= S_CONVERT;
                        cnv        <= 1'b1;
                        conv_cnt   <= '0;
                        period_cnt <= '0;
                    end else begin
                        period_cnt <= period_cnt + PERIOD_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ltc231x_stream_reader.sv
// Bench for ltc231x_stream_reader: three parameterisations, SDO models,
// a timeline model of instance A checked every cycle, plus directed literals.
module tb_ltc231x_stream_reader;

    localparam int AW = 16, ACONV = 3, ADIV = 1, AP = 50;
    localparam int AT = ACONV + 2 * ADIV * AW + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: 16-bit, DIV 1, period 50
    logic        a_start = 0, a_cont = 0, a_ready = 1, a_sdo = 0;
    logic [15:0] a_dout;
    logic        a_dv, a_ovr, a_busy, a_cnv, a_sck;
    logic [15:0] a_next_word = 16'h0000;

    // Instance B: 12-bit, DIV 2
    logic        b_start = 0, b_cont = 0, b_ready = 1, b_sdo = 0;
    logic [11:0] b_dout;
    logic        b_dv, b_ovr, b_busy, b_cnv, b_sck;

    // Instance C: 16-bit, period 10 (clamped to T_MIN)
    logic        c_start = 0, c_cont = 0, c_ready = 1, c_sdo = 1;
    logic [15:0] c_dout;
    logic        c_dv, c_ovr, c_busy, c_cnv, c_sck;

    ltc231x_stream_reader #(.DATA_WIDTH(16), .CONV_CYCLES(3), .SCK_DIV(1), .SAMPLE_PERIOD(50)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .cont_en(a_cont),
        .data_out(a_dout), .data_valid(a_dv), .data_ready(a_ready), .overrun(a_ovr),
        .busy(a_busy), .cnv(a_cnv), .sck(a_sck), .sdo(a_sdo));

    ltc231x_stream_reader #(.DATA_WIDTH(12), .CONV_CYCLES(3), .SCK_DIV(2), .SAMPLE_PERIOD(64)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .cont_en(b_cont),
        .data_out(b_dout), .data_valid(b_dv), .data_ready(b_ready), .overrun(b_ovr),
        .busy(b_busy), .cnv(b_cnv), .sck(b_sck), .sdo(b_sdo));

    ltc231x_stream_reader #(.DATA_WIDTH(16), .CONV_CYCLES(3), .SCK_DIV(1), .SAMPLE_PERIOD(10)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .cont_en(c_cont),
        .data_out(c_dout), .data_valid(c_dv), .data_ready(c_ready), .overrun(c_ovr),
        .busy(c_busy), .cnv(c_cnv), .sck(c_sck), .sdo(c_sdo));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ADC SDO models: word latched on CNV rise, next bit presented after each SCK rise.
    logic [15:0] a_cur = 0;
    int          a_bit = 0;
    logic        a_cnv_q = 0, a_sck_q = 1;
    logic [11:0] b_cur = 12'h9F1;
    int          b_bit = 0;
    logic        b_cnv_q = 0, b_sck_q = 1;
    always @(negedge clk) begin
        if (a_cnv && !a_cnv_q) begin
            a_cur = a_next_word;
            a_bit = 0;
        end else if (a_sck && !a_sck_q) begin
            a_bit++;
        end
        a_cnv_q = a_cnv;
        a_sck_q = a_sck;
        a_sdo   = (a_bit < 16) ? a_cur[15 - a_bit] : 1'b0;
        if (b_cnv && !b_cnv_q) begin
            b_bit = 0;
        end else if (b_sck && !b_sck_q) begin
            b_bit++;
        end
        b_cnv_q = b_cnv;
        b_sck_q = b_sck;
        b_sdo   = (b_bit < 12) ? b_cur[11 - b_bit] : 1'b0;
    end

    // Timeline model of instance A: each sample is a fixed schedule relative to its start edge.
    int          m_cyc = 0, m_e0 = 0, m_phase = 0, r = 0, n = 0;
    logic        m_dv = 0, m_ovr = 0, m_busy = 0, m_ld = 0, m_req = 0;
    logic        e_cnv, e_sck;
    logic [15:0] m_dout = 0, m_word = 0;
    always begin
        @(posedge clk);
        m_cyc++;
        if (reset) begin
            m_phase = 0; m_dv = 0; m_dout = 0; m_ovr = 0; m_busy = 0;
        end else begin
            m_ld  = 0;
            m_ovr = 0;
            m_req = a_start | a_cont;
            r     = m_cyc - m_e0;
            case (m_phase)
                0: begin
                    m_busy = m_req;
                    if (m_req) begin m_e0 = m_cyc; m_word = a_next_word; m_phase = 1; end
                end
                1: begin
                    m_busy = 1;
                    if (r == AT - 1) begin m_ld = 1; m_phase = a_cont ? 2 : 0; end
                end
                default: begin
                    m_busy = 1;
                    if (!a_cont) m_phase = 0;
                    else if (r == AP) begin m_e0 = m_cyc; m_word = a_next_word; m_phase = 1; end
                end
            endcase
            if (m_ld) begin
                m_ovr  = m_dv && !a_ready;
                m_dv   = 1;
                m_dout = m_word;
            end else if (m_dv && a_ready) begin
                m_dv = 0;
            end
        end
        r = m_cyc - m_e0;
        if (m_phase == 1) begin
            e_cnv = (r < ACONV);
            n = (r < ACONV + ADIV) ? 0 : (r - ACONV) / ADIV;
            if (n > 2 * AW) n = 2 * AW;
            e_sck = (n % 2 == 0);
        end else begin
            e_cnv = 0;
            e_sck = 1;
        end
        #3;
        if (!reset) begin
            check("a_cnv", 32'(a_cnv), 32'(e_cnv));
            check("a_sck", 32'(a_sck), 32'(e_sck));
            check("a_busy", 32'(a_busy), 32'(m_busy));
            check("a_valid", 32'(a_dv), 32'(m_dv));
            check("a_overrun", 32'(a_ovr), 32'(m_ovr));
            check("a_data", 32'(a_dout), 32'(m_dout));
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    int first_dv, first_idle, ncnv, nrise, r1, r2, cnt, cnt2, k0, k1, k2;
    logic prev;
    logic [15:0] dout_at;

    initial begin
        #1 reset = 1'b1;
        repeat (3) step();
        check("rst_cnv", 32'(a_cnv), 32'd0);
        check("rst_sck", 32'(a_sck), 32'd1);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_valid", 32'(a_dv), 32'd0);
        check("rst_overrun", 32'(a_ovr), 32'd0);
        check("rst_data", 32'(a_dout), 32'd0);
        reset = 1'b0;
        step();

        // Single shot, 16 bits, DIV 1
        a_next_word = 16'hA5C3;
        a_start = 1; step(); a_start = 0;
        first_dv = -1; first_idle = -1; ncnv = 0; nrise = 0; r1 = -1; r2 = -1; prev = 1; dout_at = 0;
        for (int k = 0; k < 46; k++) begin
            if (a_cnv) ncnv++;
            if (a_sck && !prev) begin nrise++; if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k; end
            prev = a_sck;
            if (a_dv && first_dv < 0) begin first_dv = k; dout_at = a_dout; end
            if (!a_busy && first_idle < 0) first_idle = k;
            step();
        end
        check("t1_cnv_cycles", 32'(ncnv), 32'd3);
        check("t1_sck_rises", 32'(nrise), 32'd16);
        check("t1_sck_period", 32'(r2 - r1), 32'd2);
        check("t1_valid_edge", 32'(first_dv + 1), 32'd37);
        check("t1_data", 32'(dout_at), 32'hA5C3);
        check("t1_idle_edge", 32'(first_idle + 1), 32'd38);

        // Single shot, 12 bits, DIV 2
        b_start = 1; step(); b_start = 0;
        first_dv = -1; nrise = 0; r1 = -1; r2 = -1; prev = 1;
        for (int k = 0; k < 60; k++) begin
            if (b_sck && !prev) begin nrise++; if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k; end
            prev = b_sck;
            if (b_dv && first_dv < 0) first_dv = k;
            step();
        end
        check("t2_sck_rises", 32'(nrise), 32'd12);
        check("t2_sck_period", 32'(r2 - r1), 32'd4);
        check("t2_valid_edge", 32'(first_dv + 1), 32'd53);
        check("t2_data", 32'(b_dout), 32'h9F1);

        // Continuous at period 50, consumer always ready
        a_next_word = 16'h6C39;
        a_cont = 1; step();
        k0 = -1; k1 = -1; k2 = -1; cnt = 0; cnt2 = 0; prev = 0;
        for (int k = 0; k < 170; k++) begin
            if (a_cnv && !prev) begin
                if (k0 < 0) k0 = k; else if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
            end
            prev = a_cnv;
            if (a_ovr) cnt++;
            if (a_dv && k < 150) cnt2++;
            step();
        end
        check("t3_period1", 32'(k1 - k0), 32'd50);
        check("t3_period2", 32'(k2 - k1), 32'd50);
        check("t3_valid_pulses", 32'(cnt2), 32'd3);
        check("t3_no_overrun", 32'(cnt), 32'd0);
        a_cont = 0;
        for (int k = 0; k < 100 && a_busy; k++) step();
        check("t3_stopped", 32'(a_busy), 32'd0);

        // Continuous with a period shorter than T_MIN
        c_cont = 1; step();
        k0 = -1; k1 = -1; k2 = -1; prev = 0;
        for (int k = 0; k < 120; k++) begin
            if (c_cnv && !prev) begin
                if (k0 < 0) k0 = k; else if (k1 < 0) k1 = k; else if (k2 < 0) k2 = k;
            end
            prev = c_cnv;
            step();
        end
        check("t4_period1", 32'(k1 - k0), 32'd37);
        check("t4_period2", 32'(k2 - k1), 32'd37);
        check("t4_data", 32'(c_dout), 32'hFFFF);
        c_cont = 0;
        for (int k = 0; k < 100 && c_busy; k++) step();
        check("t4_stopped", 32'(c_busy), 32'd0);

        // Overrun: two samples with the consumer stalled
        a_ready = 0;
        a_next_word = 16'h1111;
        a_start = 1; step(); a_start = 0;
        repeat (44) step();
        check("t5_first_valid", 32'(a_dv), 32'd1);
        check("t5_first_data", 32'(a_dout), 32'h1111);
        a_next_word = 16'h2222;
        a_start = 1; step(); a_start = 0;
        cnt = 0;
        for (int k = 0; k < 44; k++) begin
            if (a_ovr) cnt++;
            step();
        end
        check("t5_overrun_count", 32'(cnt), 32'd1);
        check("t5_second_data", 32'(a_dout), 32'h2222);
        a_ready = 1; step();
        check("t5_release", 32'(a_dv), 32'd0);

        // Reset in the middle of READ with a sample pending
        a_ready = 0;
        a_next_word = 16'h3333;
        a_start = 1; step(); a_start = 0;
        repeat (44) step();
        a_next_word = 16'hFFFF;
        a_start = 1; step(); a_start = 0;
        repeat (ACONV + 14) step();
        check("t6_pre_valid", 32'(a_dv), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_cnv", 32'(a_cnv), 32'd0);
        check("t6_rst_sck", 32'(a_sck), 32'd1);
        check("t6_rst_busy", 32'(a_busy), 32'd0);
        check("t6_rst_valid", 32'(a_dv), 32'd0);
        step();
        reset = 1'b0;
        a_ready = 1;
        a_next_word = 16'h0F0F;
        step();
        a_start = 1; step(); a_start = 0;
        repeat (40) step();
        check("t6_clean_data", 32'(a_dout), 32'h0F0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
